// File: rtl/gray_decoder_monitor.sv
// -----------------------------------------------------------------------------
// gray_decoder_monitor
//   Receive side of a Gray-code counter link. Each valid Gray sample is decoded
//   to binary and checked to be exactly the previous count + 1 (mod 2^CBITS).
//   The block tracks lock, pulses on wrap-around and on step errors, and keeps
//   a saturating error count. All outputs are registered (one-cycle latency).
//
//   Optional feature (compile-time macro): GRAY_DEC_DUP_ALLOW_EN
//     defined   : a repeated sample (dup) is tolerated in LOCKED and RESYNC;
//                 it is still reported on bin_vld but state, good and err_cnt hold.
//     undefined : a dup is handled like any other out-of-sequence sample.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous reset, active-high (wins over gray_vld)
//   gray_in   in   CBITS   Gray-coded count
//   gray_vld  in   1       gray_in valid this cycle
//   bin_out   out  CBITS   decoded binary value of the last accepted sample
//   bin_vld   out  1       one-cycle pulse: bin_out updated
//   step_err  out  1       one-cycle pulse: out-of-sequence sample while LOCKED
//   wrap      out  1       one-cycle pulse: accepted step from all-ones to 0
//   locked    out  1       monitor is in the LOCKED state
//   err_cnt   out  ECBITS  saturating count of step errors
// -----------------------------------------------------------------------------
module gray_decoder_monitor #(
  parameter int CBITS  = 16,
  parameter int ECBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CBITS-1:0]  gray_in,
  input  logic              gray_vld,
  output logic [CBITS-1:0]  bin_out,
  output logic              bin_vld,
  output logic              step_err,
  output logic              wrap,
  output logic              locked,
  output logic [ECBITS-1:0] err_cnt
);

`ifdef GRAY_DEC_DUP_ALLOW_EN
  localparam bit DupAllow = 1'b1;
`else
  localparam bit DupAllow = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [CBITS-1:0]   prev_q,     prev_d;
  logic               good_q,     good_d;   // one in-sequence sample seen in RESYNC
  logic [CBITS-1:0]   bin_out_q,  bin_out_d;
  logic               bin_vld_q,  bin_vld_d;
  logic               step_err_q, step_err_d;
  logic               wrap_q,     wrap_d;
  logic [ECBITS-1:0]  err_cnt_q,  err_cnt_d;

  logic [CBITS-1:0]   bin_dec;
  logic [CBITS-1:0]   prev_inc;
  logic               inc;
  logic               dup_ok;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < CBITS; i++) begin
      bin_dec[i] = ^(gray_in >> i);
    end
  end

  // prev+1 kept at CBITS bits so all-ones naturally rolls over to 0.
  assign prev_inc = prev_q + CBITS'(1);
  assign inc      = (bin_dec == prev_inc);
  assign dup_ok   = DupAllow && (bin_dec == prev_q);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    bin_out_d  = bin_out_q;
    bin_vld_d  = 1'b0;
    step_err_d = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (gray_vld) begin
      bin_out_d = bin_dec;
      bin_vld_d = 1'b1;
      prev_d    = bin_dec;

      unique case (state_q)
        IDLE: begin
          // First sample after reset is taken as the reference, never checked.
          state_d = LOCKED;
          good_d  = 1'b0;
        end
        LOCKED: begin
          if (inc) begin
            wrap_d = (prev_q == '1);
          end else if (!dup_ok) begin
            step_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECBITS'(1);
            state_d = RESYNC;
            good_d  = 1'b0;
          end
        end
        RESYNC: begin
          if (inc) begin
            wrap_d = (prev_q == '1);
            if (good_q) begin
              state_d = LOCKED;
              good_d  = 1'b0;
            end else begin
              good_d  = 1'b1;
            end
          end else if (!dup_ok) begin
            good_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= 1'b0;
      bin_out_q  <= '0;
      bin_vld_q  <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      bin_out_q  <= bin_out_d;
      bin_vld_q  <= bin_vld_d;
      step_err_q <= step_err_d;
      wrap_q     <= wrap_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bin_out  = bin_out_q;
  assign bin_vld  = bin_vld_q;
  assign step_err = step_err_q;
  assign wrap     = wrap_q;
  assign locked   = (state_q == LOCKED);
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// -----------------------------------------------------------------------------
// tb_gray_decoder_monitor
//   Directed bench for gray_decoder_monitor. Two instances share the stimulus:
//   u_dut (ECBITS=8) and u_sat (ECBITS=2, for error-counter saturation).
//   A sample-level model derives every expected output each cycle; literal
//   expectations in the stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_gray_decoder_monitor;

  localparam int CBITS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CBITS-1:0]  gray_in;
  logic              gray_vld;

  logic [CBITS-1:0]  bin_out,  s_bin_out;
  logic              bin_vld,  s_bin_vld;
  logic              step_err, s_step_err;
  logic              wrap,     s_wrap;
  logic              locked,   s_locked;
  logic [7:0]        err_cnt;
  logic [1:0]        s_err_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef GRAY_DEC_DUP_ALLOW_EN
  localparam bit DupOk = 1'b1;
`else
  localparam bit DupOk = 1'b0;
`endif

  always #5 clk = ~clk;

  gray_decoder_monitor #(.CBITS(CBITS), .ECBITS(8)) u_dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld),
    .bin_out(bin_out), .bin_vld(bin_vld), .step_err(step_err),
    .wrap(wrap), .locked(locked), .err_cnt(err_cnt)
  );

  gray_decoder_monitor #(.CBITS(CBITS), .ECBITS(2)) u_sat (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld),
    .bin_out(s_bin_out), .bin_vld(s_bin_vld), .step_err(s_step_err),
    .wrap(s_wrap), .locked(s_locked), .err_cnt(s_err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_gray(input int b);
    logic [15:0] x;
    x = b[15:0];
    return x ^ (x >> 1);
  endfunction

  // ---------------- sample-level model ----------------
  // mode: 0 = waiting for first sample, 1 = locked, 2 = resynchronising
  int m_mode = 0, m_prev = 0, m_good = 0;
  int e_bin = 0, e_cnt8 = 0, e_cnt2 = 0;
  bit e_vld = 0, e_err = 0, e_wrap = 0;

  task automatic model_step(input bit r, input bit v, input logic [15:0] g);
    int  b;
    bit  inc, dup;
    b = 0;
    for (int i = 0; i < 16; i++) b = b ^ int'(g >> i);
    e_vld = 0; e_err = 0; e_wrap = 0;
    if (r) begin
      e_bin = 0; m_mode = 0; m_prev = 0; m_good = 0; e_cnt8 = 0; e_cnt2 = 0;
    end else if (v) begin
      e_bin = b;
      e_vld = 1;
      if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        inc = (b == (m_prev + 1) % 65536);
        dup = (b == m_prev);
        if (inc) begin
          e_wrap = (m_prev == 65535);
          if (m_mode == 2) begin
            m_good++;
            if (m_good == 2) begin m_mode = 1; m_good = 0; end
          end
        end else if (dup && DupOk) begin
          // tolerated repeat: nothing else changes
        end else if (m_mode == 1) begin
          e_err  = 1;
          e_cnt8 = (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
          e_cnt2 = (e_cnt2 < 3)   ? e_cnt2 + 1 : 3;
          m_mode = 2;
          m_good = 0;
        end else begin
          m_good = 0;
        end
      end
      m_prev = b;
    end
  endtask

  // Single compare process: capture inputs at the edge, check #1 later.
  initial begin
    bit          r, v;
    logic [15:0] g;
    forever begin
      @(posedge clk);
      r = rst; v = gray_vld; g = gray_in;
      #1;
      model_step(r, v, g);
      check("bin_out",    32'(bin_out),   32'(e_bin));
      check("bin_vld",    32'(bin_vld),   32'(e_vld));
      check("step_err",   32'(step_err),  32'(e_err));
      check("wrap",       32'(wrap),      32'(e_wrap));
      check("locked",     32'(locked),    32'(m_mode == 1));
      check("err_cnt",    32'(err_cnt),   32'(e_cnt8));
      check("s_step_err", 32'(s_step_err), 32'(e_err));
      check("s_locked",   32'(s_locked),  32'(m_mode == 1));
      check("s_err_cnt",  32'(s_err_cnt), 32'(e_cnt2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [15:0] g);
    @(negedge clk);
    rst = 1'b0; gray_vld = v; gray_in = g;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit v, input logic [15:0] g);
    @(negedge clk);
    rst = 1'b1; gray_vld = v; gray_in = g;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cur;
    rst = 1'b1; gray_vld = 1'b0; gray_in = '0;

    // T1: reset state, then first sample accepted without check
    do_reset(1'b0, 16'h0000);
    check("T1 rst bin_out", 32'(bin_out), 32'h0);
    check("T1 rst bin_vld", 32'(bin_vld), 32'h0);
    check("T1 rst locked",  32'(locked),  32'h0);
    check("T1 rst err_cnt", 32'(err_cnt), 32'h0);
    step(1'b1, 16'h0000);
    check("T1 bin_out",  32'(bin_out),  32'h0);
    check("T1 bin_vld",  32'(bin_vld),  32'h1);
    check("T1 locked",   32'(locked),   32'h1);
    check("T1 step_err", 32'(step_err), 32'h0);

    // T2: count across the wrap boundary, then an idle cycle
    do_reset(1'b0, 16'h0000);
    step(1'b1, 16'h8001);               // Gray(0xFFFE), reference sample
    step(1'b1, 16'h8000);               // Gray(0xFFFF)
    check("T2 bin_out ffff", 32'(bin_out),  32'hFFFF);
    check("T2 wrap0",        32'(wrap),     32'h0);
    step(1'b1, 16'h0000);               // Gray(0)
    check("T2 bin_out 0",    32'(bin_out),  32'h0);
    check("T2 wrap1",        32'(wrap),     32'h1);
    check("T2 step_err",     32'(step_err), 32'h0);
    step(1'b0, 16'hABCD);
    check("T2 idle bin_vld", 32'(bin_vld),  32'h0);
    check("T2 idle wrap",    32'(wrap),     32'h0);
    check("T2 idle bin_out", 32'(bin_out),  32'h0);

    // T3: skip, recover, then a non-inc in RESYNC restarts recovery
    do_reset(1'b0, 16'h0000);
    step(1'b1, 16'h0007);               // Gray(5)
    step(1'b1, 16'h0004);               // Gray(7): skip
    check("T3 step_err", 32'(step_err), 32'h1);
    check("T3 err_cnt",  32'(err_cnt),  32'h1);
    check("T3 locked0",  32'(locked),   32'h0);
    step(1'b1, 16'h000C);               // Gray(8)
    check("T3 locked after 8", 32'(locked), 32'h0);
    step(1'b1, 16'h000D);               // Gray(9)
    check("T3 locked after 9", 32'(locked), 32'h1);
    step(1'b1, to_gray(20));
    check("T3 err_cnt2", 32'(err_cnt), 32'h2);
    step(1'b1, to_gray(21));
    step(1'b1, to_gray(30));            // out of sequence inside RESYNC
    check("T3 resync no err", 32'(step_err), 32'h0);
    step(1'b1, to_gray(31));
    check("T3 still unlocked", 32'(locked), 32'h0);
    step(1'b1, to_gray(32));
    check("T3 relocked", 32'(locked), 32'h1);
    check("T3 err_cnt hold", 32'(err_cnt), 32'h2);

    // T4: duplicate sample while locked
    do_reset(1'b0, 16'h0000);
    step(1'b1, 16'h0002);               // Gray(3)
    step(1'b1, 16'h0002);
    check("T4 bin_vld", 32'(bin_vld), 32'h1);
    check("T4 bin_out", 32'(bin_out), 32'h3);
`ifdef GRAY_DEC_DUP_ALLOW_EN
    check("T4 step_err", 32'(step_err), 32'h0);
    check("T4 locked",   32'(locked),   32'h1);
    check("T4 err_cnt",  32'(err_cnt),  32'h0);
`else
    check("T4 step_err", 32'(step_err), 32'h1);
    check("T4 locked",   32'(locked),   32'h0);
    check("T4 err_cnt",  32'(err_cnt),  32'h1);
`endif

    // T5: five errors; the 2-bit counter saturates at 3
    do_reset(1'b0, 16'h0000);
    step(1'b1, to_gray(0));
    cur = 0;
    for (int k = 0; k < 5; k++) begin
      cur += 5;
      step(1'b1, to_gray(cur));
      check("T5 s_step_err", 32'(s_step_err), 32'h1);
      step(1'b1, to_gray(cur + 1));
      step(1'b1, to_gray(cur + 2));
      cur += 2;
    end
    check("T5 s_err_cnt sat", 32'(s_err_cnt), 32'h3);
    check("T5 err_cnt",       32'(err_cnt),   32'h5);
    check("T5 locked",        32'(s_locked),  32'h1);

    // T6: reset with a valid sample mid-stream
    do_reset(1'b1, to_gray(cur + 1));
    check("T6 bin_out",  32'(bin_out),  32'h0);
    check("T6 bin_vld",  32'(bin_vld),  32'h0);
    check("T6 step_err", 32'(step_err), 32'h0);
    check("T6 wrap",     32'(wrap),     32'h0);
    check("T6 locked",   32'(locked),   32'h0);
    check("T6 err_cnt",  32'(err_cnt),  32'h0);
    step(1'b1, 16'h1234);
    check("T6 first bin_out",  32'(bin_out),  32'h1C27);
    check("T6 first step_err", 32'(step_err), 32'h0);
    check("T6 first locked",   32'(locked),   32'h1);

    step(1'b0, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
